// File: rtl/lmdpl_nor_round_ctrl_pkg.sv
// Shared types and the LMDPL NOR lookup map used by the round sequencer.
// The table map converts a gate's {m_out,m_in1,m_in0} mask triple into its 8-bit selector table.
package lmdpl_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_PRE   = 2'd2,
        S_EVAL  = 2'd3
    } state_t;

    localparam int M_IN0 = 0;
    localparam int M_IN1 = 1;
    localparam int M_OUT = 2;

    // Entry k (k = {m_out,m_in1,m_in0}) lives at bits [8k+7:8k].
    localparam logic [63:0] NOR_TABLE = {8'h78, 8'hB4, 8'hD2, 8'hE1,
                                         8'h87, 8'h4B, 8'h2D, 8'h1E};

    function automatic logic [7:0] nor_table(input logic [2:0] m);
        logic [5:0] idx;
        idx = {m[M_OUT], m[M_IN1], m[M_IN0], 3'b000};
        return NOR_TABLE[idx +: 8];
    endfunction

endpackage

// File: rtl/lmdpl_nor_round_ctrl_if.sv
// Handshake/bus bundle between the round sequencer and its PRNG, operand source,
// result sink and NOR array.
interface lmdpl_nor_round_ctrl_if #(
    parameter int N_GATES = 4,
    parameter int CNT_W   = 16
);
    logic                   go;
    logic                   rnd_valid;
    logic                   rnd_ready;
    logic [3*N_GATES-1:0]   rnd_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   pre;
    logic                   eval;
    logic [8*N_GATES-1:0]   tbl;
    logic [3*N_GATES-1:0]   mask_out;
    logic                   out_valid;
    logic                   busy;
    logic [CNT_W-1:0]       round_cnt;

    modport slave (
        input  go, rnd_valid, rnd_data, in_valid,
        output rnd_ready, in_ready, pre, eval, tbl, mask_out, out_valid, busy, round_cnt
    );

    modport master (
        output go, rnd_valid, rnd_data, in_valid,
        input  rnd_ready, in_ready, pre, eval, tbl, mask_out, out_valid, busy, round_cnt
    );
endinterface

// File: rtl/lmdpl_nor_round_ctrl_phase_counter.sv
// Loadable down-counter with a zero flag; times both the precharge and evaluate phases.
module lmdpl_phase_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/lmdpl_nor_round_ctrl.sv
// Round sequencer for a bank of LMDPL NOR gates: fetches fresh masks every round,
// builds per-gate tables and drives the precharge/evaluate phases.
//
// state | meaning
// IDLE  | waiting for go; outputs quiet, mask_out holds last round's masks
// FETCH | precharging, waiting for one PRNG word
// PRE   | precharging for PRE_CYCLES, then waiting for operands
// EVAL  | tables driven onto the array for EVAL_CYCLES
module lmdpl_nor_round_ctrl
    import lmdpl_ctrl_pkg::*;
#(
    parameter int N_GATES     = 4,
    parameter int PRE_CYCLES  = 1,
    parameter int EVAL_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    lmdpl_nor_round_ctrl_if.slave  bus
);
    localparam int PH_MAX = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] PRE_LOAD  = PH_W'(PRE_CYCLES - 1);
    localparam logic [PH_W-1:0] EVAL_LOAD = PH_W'(EVAL_CYCLES - 1);

    state_t                 r_state;
    logic                   r_rnd_ready;
    logic                   r_pre;
    logic                   r_eval;
    logic                   r_busy;
    logic [8*N_GATES-1:0]   r_tbl;
    logic [8*N_GATES-1:0]   r_tbl_out;
    logic [3*N_GATES-1:0]   r_mask;
    logic [CNT_W-1:0]       r_round_cnt;

    logic [8*N_GATES-1:0]   w_tbl_next;
    logic                   w_accept;
    logic                   w_start_eval;
    logic                   w_eval_done;
    logic                   w_cnt_zero;
    logic                   w_load;
    logic                   w_dec;
    logic [PH_W-1:0]        w_load_val;

    for (genvar g = 0; g < N_GATES; g++) begin : g_tbl
        assign w_tbl_next[8*g +: 8] = nor_table(bus.rnd_data[3*g +: 3]);
    end

    assign w_accept     = (r_state == S_FETCH) && bus.rnd_valid && r_rnd_ready;
    assign w_start_eval = (r_state == S_PRE) && w_cnt_zero && bus.in_valid;
    assign w_eval_done  = (r_state == S_EVAL) && w_cnt_zero;
    assign w_load       = w_accept || w_start_eval;
    assign w_load_val   = w_accept ? PRE_LOAD : EVAL_LOAD;
    assign w_dec        = (r_state == S_PRE) || (r_state == S_EVAL);

    lmdpl_phase_counter #(.W(PH_W)) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rnd_ready <= 1'b0;
            r_pre       <= 1'b0;
            r_eval      <= 1'b0;
            r_busy      <= 1'b0;
            r_tbl       <= '0;
            r_tbl_out   <= '0;
            r_mask      <= '0;
            r_round_cnt <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.go) begin
                        r_state     <= S_FETCH;
                        r_rnd_ready <= 1'b1;
                        r_pre       <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (w_accept) begin
                        r_state     <= S_PRE;
                        r_rnd_ready <= 1'b0;
                        r_mask      <= bus.rnd_data;
                        r_tbl       <= w_tbl_next;
                    end
                end
                S_PRE: begin
                    if (w_start_eval) begin
                        r_state   <= S_EVAL;
                        r_pre     <= 1'b0;
                        r_eval    <= 1'b1;
                        r_tbl_out <= r_tbl;
                    end
                end
                S_EVAL: begin
                    // Tables drop to zero on exit, guaranteeing a zero gap before the next EVAL.
                    if (w_eval_done) begin
                        r_eval      <= 1'b0;
                        r_tbl_out   <= '0;
                        r_round_cnt <= r_round_cnt + 1'b1;
                        if (bus.go) begin
                            r_state     <= S_FETCH;
                            r_rnd_ready <= 1'b1;
                            r_pre       <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rnd_ready = r_rnd_ready;
    assign bus.in_ready  = w_start_eval;
    assign bus.pre       = r_pre;
    assign bus.eval      = r_eval;
    assign bus.tbl       = r_tbl_out;
    assign bus.mask_out  = r_mask;
    assign bus.out_valid = w_eval_done;
    assign bus.busy      = r_busy;
    assign bus.round_cnt = r_round_cnt;
endmodule

// File: tb/tb_lmdpl_nor_round_ctrl.sv
// Directed self-checking bench for the LMDPL NOR round sequencer (2 gates, 1 precharge, 2 eval cycles).
module tb_lmdpl_nor_round_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   hs_cnt;
    int   hs_base;
    int   ov_cnt;
    int   guard;
    logic       prev_eval;
    logic [15:0] prev_tbl;
    logic [7:0] exp_tbl [8];

    lmdpl_nor_round_ctrl_if #(.N_GATES(2), .CNT_W(16)) bus ();

    lmdpl_nor_round_ctrl #(
        .N_GATES     (2),
        .PRE_CYCLES  (1),
        .EVAL_CYCLES (2),
        .CNT_W       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return bus.eval;
            1:       return bus.out_valid;
            default: return bus.rnd_ready;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string tag);
        int k;
        k = 0;
        while (!pick(sel) && k < 50) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, pick(sel)}, 32'd1);
    endtask

    always @(posedge clk) begin
        if (!rst && bus.rnd_valid && bus.rnd_ready) hs_cnt++;
    end

    // Continuous invariants: table gating, phase exclusivity and zero gap before EVAL.
    always @(negedge clk) begin
        if (!bus.eval) chk("tbl_zero_outside_eval", {16'd0, bus.tbl}, 32'd0);
        else chk("tbl_matches_mask", {16'd0, bus.tbl},
                 {16'd0, exp_tbl[bus.mask_out[5:3]], exp_tbl[bus.mask_out[2:0]]});
        chk("pre_eval_exclusive", {31'd0, bus.pre & bus.eval}, 32'd0);
        chk("busy_vs_phase", {31'd0, bus.busy}, {31'd0, bus.pre | bus.eval});
        if (bus.eval && !prev_eval) chk("zero_gap_before_eval", {16'd0, prev_tbl}, 32'd0);
        prev_eval = bus.eval;
        prev_tbl  = bus.tbl;
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        hs_cnt = 0;
        prev_eval = 1'b0;
        prev_tbl = '0;
        exp_tbl = '{8'h1E, 8'h2D, 8'h4B, 8'h87, 8'hE1, 8'hD2, 8'hB4, 8'h78};
        rst = 1'b1;
        bus.go = 1'b0;
        bus.rnd_valid = 1'b0;
        bus.rnd_data = '0;
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_pre", {31'd0, bus.pre}, 32'd0);
        chk("rst_rnd_ready", {31'd0, bus.rnd_ready}, 32'd0);
        chk("rst_mask", {26'd0, bus.mask_out}, 32'd0);
        chk("rst_round_cnt", {16'd0, bus.round_cnt}, 32'd0);
        rst = 1'b0;

        // Basic round with hand-timed latency
        bus.go = 1'b1;
        bus.rnd_valid = 1'b1;
        bus.rnd_data = 6'b101_000;
        bus.in_valid = 1'b1;
        tick();
        chk("fetch_rnd_ready", {31'd0, bus.rnd_ready}, 32'd1);
        chk("fetch_pre", {31'd0, bus.pre}, 32'd1);
        chk("fetch_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        bus.rnd_valid = 1'b0;
        chk("pre_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("pre_mask", {26'd0, bus.mask_out}, 32'h28);
        chk("pre_rnd_ready", {31'd0, bus.rnd_ready}, 32'd0);
        tick();
        chk("eval1_eval", {31'd0, bus.eval}, 32'd1);
        chk("eval1_tbl", {16'd0, bus.tbl}, 32'hD21E);
        chk("eval1_out_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        chk("eval2_tbl", {16'd0, bus.tbl}, 32'hD21E);
        chk("eval2_out_valid", {31'd0, bus.out_valid}, 32'd1);
        bus.go = 1'b0;
        tick();
        chk("basic_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("basic_round_cnt", {16'd0, bus.round_cnt}, 32'd1);
        chk("basic_mask_hold", {26'd0, bus.mask_out}, 32'h28);

        // All eight mask codes, back to back
        bus.go = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.rnd_data = {3'(c), 3'(c)};
            bus.rnd_valid = 1'b1;
            wait_for(2, "codes_rnd_ready");
            tick();
            bus.rnd_valid = 1'b0;
            wait_for(0, "codes_eval");
            chk("codes_tbl", {16'd0, bus.tbl}, {16'd0, exp_tbl[c], exp_tbl[c]});
            chk("codes_mask", {26'd0, bus.mask_out}, {26'd0, 3'(c), 3'(c)});
            wait_for(1, "codes_out_valid");
            if (c == 7) bus.go = 1'b0;
            tick();
        end
        chk("codes_round_cnt", {16'd0, bus.round_cnt}, 32'd9);
        chk("codes_idle", {31'd0, bus.busy}, 32'd0);

        // Stalls on PRNG and operands, then go dropped during EVAL
        bus.go = 1'b1;
        bus.rnd_data = 6'b011_110;
        bus.in_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_fetch_pre", {31'd0, bus.pre}, 32'd1);
            chk("stall_fetch_rdy", {31'd0, bus.rnd_ready}, 32'd1);
            chk("stall_fetch_mask", {26'd0, bus.mask_out}, 32'h3F);
            tick();
        end
        bus.rnd_valid = 1'b1;
        tick();
        bus.rnd_valid = 1'b0;
        chk("stall_mask_loaded", {26'd0, bus.mask_out}, 32'h1E);
        for (int i = 0; i < 3; i++) begin
            chk("stall_pre_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("stall_pre_pre", {31'd0, bus.pre}, 32'd1);
            tick();
        end
        bus.in_valid = 1'b1;
        #1;
        chk("stall_in_ready_rise", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("stall_eval_start", {31'd0, bus.eval}, 32'd1);
        chk("stall_tbl", {16'd0, bus.tbl}, 32'h87B4);
        bus.go = 1'b0;
        wait_for(1, "godrop_out_valid");
        tick();
        chk("godrop_busy", {31'd0, bus.busy}, 32'd0);
        chk("godrop_round_cnt", {16'd0, bus.round_cnt}, 32'd10);
        chk("godrop_mask_hold", {26'd0, bus.mask_out}, 32'h1E);

        // Reset in the first EVAL cycle
        bus.go = 1'b1;
        bus.rnd_valid = 1'b1;
        bus.rnd_data = 6'b010_001;
        wait_for(0, "rstmid_eval");
        chk("rstmid_tbl", {16'd0, bus.tbl}, 32'h4B2D);
        rst = 1'b1;
        tick();
        chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rstmid_eval", {31'd0, bus.eval}, 32'd0);
        chk("rstmid_pre", {31'd0, bus.pre}, 32'd0);
        chk("rstmid_tbl0", {16'd0, bus.tbl}, 32'd0);
        chk("rstmid_mask", {26'd0, bus.mask_out}, 32'd0);
        chk("rstmid_round_cnt", {16'd0, bus.round_cnt}, 32'd0);
        chk("rstmid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        hs_base = hs_cnt;
        rst = 1'b0;
        bus.rnd_data = 6'b110_111;
        wait_for(0, "rstmid_fresh_eval");
        chk("rstmid_fresh_tbl", {16'd0, bus.tbl}, 32'hB478);
        chk("rstmid_fresh_mask", {26'd0, bus.mask_out}, 32'h37);
        chk("rstmid_one_word", hs_cnt - hs_base, 32'd1);
        bus.go = 1'b0;
        wait_for(1, "rstmid_out_valid");
        tick();
        chk("rstmid_round_cnt1", {16'd0, bus.round_cnt}, 32'd1);

        // 100 back-to-back rounds with changing masks
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hs_base = hs_cnt;
        ov_cnt = 0;
        guard = 0;
        bus.go = 1'b1;
        bus.rnd_valid = 1'b1;
        bus.in_valid = 1'b1;
        while (ov_cnt < 100 && guard < 2000) begin
            bus.rnd_data = 6'($urandom);
            tick();
            guard++;
            if (bus.out_valid) begin
                ov_cnt++;
                if (ov_cnt == 100) bus.go = 1'b0;
            end
        end
        tick();
        chk("b2b_out_valid_pulses", ov_cnt, 32'd100);
        chk("b2b_round_cnt", {16'd0, bus.round_cnt}, 32'd100);
        chk("b2b_prng_words", hs_cnt - hs_base, 32'd100);
        chk("b2b_idle", {31'd0, bus.busy}, 32'd0);
        chk("b2b_cycles", guard, 32'd400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
